uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 39 +++
 rtl/uart_tx_fifo.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_fifo_if                                               |
// | Purpose  : Handshake/status bundle between a byte producer and the       |
// |            buffered UART transmitter.                                    |
// | Signals  : i_Tx_DV      write strobe (producer -> transmitter)           |
// |            i_Tx_Byte    data word, bit 0 sent first                      |
// |            o_Tx_Serial  serial line, idle high                           |
// |            o_Tx_Active  frame in progress                                |
// |            o_Tx_Done    one-cycle end-of-frame pulse                     |
// |            o_Fifo_Full  FIFO holds FIFO_DEPTH entries                    |
// |            o_Fifo_Empty FIFO holds no entries                            |
// |            o_Overflow   one-cycle pulse for a write dropped while full   |
// | Modports : master (producer side), slave (transmitter side)             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Byte;
  logic                 o_Tx_Serial;
  logic                 o_Tx_Active;
  logic                 o_Tx_Done;
  logic                 o_Fifo_Full;
  logic                 o_Fifo_Empty;
  logic                 o_Overflow;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Full, o_Fifo_Empty, o_Overflow
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Full, o_Fifo_Empty, o_Overflow
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                                  |
// | Purpose  : UART transmitter fed by a small transmit FIFO. Frames are     |
// |            start + DATA_BITS (LSB first) + optional parity + stop bits, |
// |            each bit CLKS_PER_BIT clocks; queued frames go out            |
// |            back-to-back.                                                 |
// | Ports    : i_Clock    rising-edge clock                                  |
// |            i_Reset_n  synchronous active-low reset                       |
// |            tx_if      uart_tx_fifo_if.slave (strobe, data, line, status) |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 100,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          i_Clock,
  input  logic          i_Reset_n,
  uart_tx_fifo_if.slave tx_if
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int c_IDX_W = $clog2(DATA_BITS);
  localparam int c_AW    = $clog2(FIFO_DEPTH);

  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_IDX_W-1:0] c_DATA_LAST = c_IDX_W'(DATA_BITS - 1);
  localparam logic [c_IDX_W-1:0] c_STOP_LAST = c_IDX_W'(STOP_BITS - 1);
  localparam logic               c_PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [c_AW:0]        wr_ptr_q, rd_ptr_q;
  logic [c_AW:0]        wr_ptr_d, rd_ptr_d;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [c_CNT_W-1:0]   clk_cnt_q;
  logic [c_IDX_W-1:0]   bit_idx_q;
  logic                 serial_q;
  logic                 active_q;
  logic                 done_q;
  logic                 ovf_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 frame_end;
  logic [DATA_BITS-1:0] head;

  // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                      (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
  assign wr_ptr_d   = wr_ptr_q + (c_AW+1)'(1);
  assign rd_ptr_d   = rd_ptr_q + (c_AW+1)'(1);
  assign head       = mem_q[rd_ptr_q[c_AW-1:0]];

  // Both flags come from registered pointers only, so a pop in this cycle
  // never frees a slot for a push in the same cycle, and a fresh push is
  // not visible to the transmitter until the following cycle.
  assign push      = tx_if.i_Tx_DV && !fifo_full;
  assign bit_end   = (clk_cnt_q == c_CNT_LAST);
  assign frame_end = (state_q == S_STOP) && bit_end && (bit_idx_q == c_STOP_LAST);
  assign pop       = ((state_q == S_IDLE) || frame_end) && !fifo_empty;

  always_ff @(posedge i_Clock) begin
    if (i_Reset_n && push) begin
      mem_q[wr_ptr_q[c_AW-1:0]] <= tx_if.i_Tx_Byte;
    end
  end

  // The line is registered from the current state, so it trails the state
  // register by one clock; every bit still lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= tx_if.i_Tx_DV && fifo_full;
      if (push) begin
        wr_ptr_q <= wr_ptr_d;
      end

      case (state_q)
        S_IDLE: begin
          serial_q <= 1'b1;
        end
        S_START: begin
          serial_q <= 1'b0;
          if (bit_end) begin
            clk_cnt_q <= '0;
            state_q   <= S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + c_CNT_W'(1);
          end
        end
        S_DATA: begin
          serial_q <= shift_q[0];
          if (bit_end) begin
            clk_cnt_q <= '0;
            shift_q   <= shift_q >> 1;
            if (bit_idx_q == c_DATA_LAST) begin
              bit_idx_q <= '0;
              state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + c_IDX_W'(1);
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + c_CNT_W'(1);
          end
        end
        S_PARITY: begin
          serial_q <= parity_q;
          if (bit_end) begin
            clk_cnt_q <= '0;
            state_q   <= S_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + c_CNT_W'(1);
          end
        end
        S_STOP: begin
          serial_q <= 1'b1;
          if (bit_end) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == c_STOP_LAST) begin
              bit_idx_q <= '0;
              done_q    <= 1'b1;
              state_q   <= S_IDLE;
              active_q  <= 1'b0;
            end else begin
              bit_idx_q <= bit_idx_q + c_IDX_W'(1);
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + c_CNT_W'(1);
          end
        end
        default: begin
          state_q   <= S_IDLE;
          serial_q  <= 1'b1;
          active_q  <= 1'b0;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
        end
      endcase

      // Loading a new frame overrides the IDLE fall-through at frame end,
      // giving back-to-back frames with Active held high.
      if (pop) begin
        shift_q   <= head;
        parity_q  <= (^head) ^ c_PAR_ODD;
        rd_ptr_q  <= rd_ptr_d;
        active_q  <= 1'b1;
        clk_cnt_q <= '0;
        bit_idx_q <= '0;
        state_q   <= S_START;
      end
    end
  end

  assign tx_if.o_Tx_Serial  = serial_q;
  assign tx_if.o_Tx_Active  = active_q;
  assign tx_if.o_Tx_Done    = done_q;
  assign tx_if.o_Fifo_Full  = fifo_full;
  assign tx_if.o_Fifo_Empty = fifo_empty;
  assign tx_if.o_Overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_tx_fifo                                               |
// | Purpose  : Self-checking bench for uart_tx_fifo. Three instances:        |
// |            A = 8N1, B = 7 data / even parity / 2 stop, C = 8 / odd / 1,  |
// |            all CLKS_PER_BIT=4, FIFO_DEPTH=4. A cycle-level reference     |
// |            model (queue occupancy + frame timer) predicts every output.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int NDUT  = 3;
  localparam int DBS  [NDUT] = '{8, 7, 8};
  localparam int PARS [NDUT] = '{0, 2, 1};
  localparam int SBS  [NDUT] = '{1, 2, 1};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0] tb_dv = '0;
  logic [8:0]      tb_data [NDUT];
  logic [NDUT-1:0] ser, act, done, full, empty, ovf;

  uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
  uart_tx_fifo_if #(.DATA_BITS(7)) if_b ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_c ();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
    u_a (.i_Clock(clk), .i_Reset_n(rst_n), .tx_if(if_a));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH))
    u_b (.i_Clock(clk), .i_Reset_n(rst_n), .tx_if(if_b));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
    u_c (.i_Clock(clk), .i_Reset_n(rst_n), .tx_if(if_c));

  assign if_a.i_Tx_DV = tb_dv[0];  assign if_a.i_Tx_Byte = tb_data[0][7:0];
  assign if_b.i_Tx_DV = tb_dv[1];  assign if_b.i_Tx_Byte = tb_data[1][6:0];
  assign if_c.i_Tx_DV = tb_dv[2];  assign if_c.i_Tx_Byte = tb_data[2][7:0];

  assign ser   = {if_c.o_Tx_Serial,  if_b.o_Tx_Serial,  if_a.o_Tx_Serial};
  assign act   = {if_c.o_Tx_Active,  if_b.o_Tx_Active,  if_a.o_Tx_Active};
  assign done  = {if_c.o_Tx_Done,    if_b.o_Tx_Done,    if_a.o_Tx_Done};
  assign full  = {if_c.o_Fifo_Full,  if_b.o_Fifo_Full,  if_a.o_Fifo_Full};
  assign empty = {if_c.o_Fifo_Empty, if_b.o_Fifo_Empty, if_a.o_Fifo_Empty};
  assign ovf   = {if_c.o_Overflow,   if_b.o_Overflow,   if_a.o_Overflow};

  int tests = 0;
  int fails = 0;

  // Reference model state: FIFO contents as a circular array plus a count,
  // and a per-instance countdown of cycles left in the frame on the line.
  int              m_cnt  [NDUT];
  int              m_head [NDUT];
  int              m_busy [NDUT];
  logic [8:0]      m_fifo [NDUT][DEPTH];
  logic [15:0]     m_bits [NDUT];
  logic [NDUT-1:0] e_ser, e_act, e_done, e_full, e_empty, e_ovf;
  bit              m_valid = 1'b0;

  int              acc_act  [NDUT];
  int              acc_done [NDUT];
  int              acc_ovf  [NDUT];
  int              acc_runs [NDUT];
  int              acc_low  [NDUT];
  logic [NDUT-1:0] prev_act;

  task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h, expected %0h @%0t", nm, d, got, exp, $time);
    end
  endtask

  function automatic int flen(input int d);
    return (1 + DBS[d] + ((PARS[d] != 0) ? 1 : 0) + SBS[d]) * CPB;
  endfunction

  // Line bits of one frame, slot 0 first: start, data LSB first, parity, stops.
  function automatic logic [15:0] frame_bits(input int d, input logic [8:0] v);
    logic [15:0] b;
    int n;
    int ones;
    b = '1;
    b[0] = 1'b0;
    n = 1;
    ones = 0;
    for (int i = 0; i < DBS[d]; i++) begin
      b[4'(n)] = v[4'(i)];
      ones += v[4'(i)] ? 1 : 0;
      n++;
    end
    if (PARS[d] == 1) b[4'(n)] = ((ones % 2) == 0);
    if (PARS[d] == 2) b[4'(n)] = ((ones % 2) == 1);
    return b;
  endfunction

  task automatic model_step();
    int bb;
    int tail;
    bit pop;
    bit push;
    for (int d = 0; d < NDUT; d++) begin
      if (!rst_n) begin
        m_cnt[d] = 0; m_head[d] = 0; m_busy[d] = 0;
        e_ser[d] = 1'b1; e_act[d] = 1'b0; e_done[d] = 1'b0;
        e_ovf[d] = 1'b0; e_full[d] = 1'b0; e_empty[d] = 1'b1;
      end else begin
        bb   = m_busy[d];
        tail = (m_head[d] + m_cnt[d]) % DEPTH;
        e_ovf[d]  = tb_dv[d] && (m_cnt[d] == DEPTH);
        e_done[d] = (bb == 1);
        e_ser[d]  = (bb > 0) ? m_bits[d][4'((flen(d) - bb) / CPB)] : 1'b1;
        pop  = (bb <= 1) && (m_cnt[d] > 0);
        push = tb_dv[d] && (m_cnt[d] < DEPTH);
        if (pop) begin
          m_bits[d] = frame_bits(d, m_fifo[d][m_head[d]]);
          m_head[d] = (m_head[d] + 1) % DEPTH;
          m_busy[d] = flen(d);
          m_cnt[d]--;
        end else if (bb > 0) begin
          m_busy[d] = bb - 1;
        end
        if (push) begin
          m_fifo[d][tail] = tb_data[d] & 9'((1 << DBS[d]) - 1);
          m_cnt[d]++;
        end
        e_act[d]   = (m_busy[d] > 0);
        e_full[d]  = (m_cnt[d] == DEPTH);
        e_empty[d] = (m_cnt[d] == 0);
      end
    end
    m_valid = 1'b1;
  endtask

  task automatic clear_acc();
    for (int d = 0; d < NDUT; d++) begin
      acc_act[d] = 0; acc_done[d] = 0; acc_ovf[d] = 0; acc_runs[d] = 0; acc_low[d] = 0;
    end
    prev_act = act;
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs are
  // compared on the falling edge, then the caller drives the next inputs.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      if (m_valid) begin
        chk("model_serial", d, 32'(ser[d]),   32'(e_ser[d]));
        chk("model_active", d, 32'(act[d]),   32'(e_act[d]));
        chk("model_done",   d, 32'(done[d]),  32'(e_done[d]));
        chk("model_full",   d, 32'(full[d]),  32'(e_full[d]));
        chk("model_empty",  d, 32'(empty[d]), 32'(e_empty[d]));
        chk("model_ovf",    d, 32'(ovf[d]),   32'(e_ovf[d]));
      end
      acc_act[d]  += act[d] ? 1 : 0;
      acc_done[d] += done[d] ? 1 : 0;
      acc_ovf[d]  += ovf[d] ? 1 : 0;
      acc_low[d]  += ser[d] ? 0 : 1;
      if (act[d] && !prev_act[d]) acc_runs[d]++;
    end
    prev_act = act;
  endtask

  typedef struct {
    int          dut;
    logic [8:0]  data;
    logic [15:0] bits;
    int          nbits;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          errs;
    logic [15:0] got_bits;
    logic [15:0] msk;
    int          d;

    vecs[0] = '{0, 9'h0A5, 16'h034A, 10};
    vecs[1] = '{1, 9'h003, 16'h0606, 11};
    vecs[2] = '{2, 9'h000, 16'h0600, 11};
    vecs[3] = '{2, 9'h001, 16'h0402, 11};
    vecs[4] = '{0, 9'h0FF, 16'h03FE, 10};
    vecs[5] = '{0, 9'h000, 16'h0200, 10};
    vecs[6] = '{1, 9'h055, 16'h06AA, 11};

    for (int i = 0; i < NDUT; i++) tb_data[i] = '0;
    tb_dv = '0;
    rst_n = 1'b0;
    clear_acc();
    // DV held high during reset must be ignored.
    tb_dv = '1;
    tick(); tick();
    tb_dv = '0;
    tick();
    for (int i = 0; i < NDUT; i++) begin
      chk("reset_serial", i, 32'(ser[i]), 32'd1);
      chk("reset_active", i, 32'(act[i]), 32'd0);
      chk("reset_empty",  i, 32'(empty[i]), 32'd1);
      chk("reset_full",   i, 32'(full[i]), 32'd0);
    end
    rst_n = 1'b1;
    tick(); tick();

    // Single-frame vectors with hand-derived line patterns.
    for (int v = 0; v < 7; v++) begin
      d = vecs[v].dut;
      clear_acc();
      tb_data[d] = vecs[v].data;
      tb_dv[d] = 1'b1;
      tick();
      tb_dv[d] = 1'b0;
      errs = 0;
      got_bits = '0;
      if (ser[d] !== 1'b1) errs++;
      tick();
      if (ser[d] !== 1'b1) errs++;
      for (int k = 0; k < vecs[v].nbits * CPB; k++) begin
        tick();
        if (ser[d] !== vecs[v].bits[4'(k / CPB)]) errs++;
        if ((k % CPB) == CPB / 2) got_bits[4'(k / CPB)] = ser[d];
      end
      tick(); tick();
      msk = 16'((1 << vecs[v].nbits) - 1);
      chk("vec_line_samples", d, 32'(errs), 32'd0);
      chk("vec_frame_bits",   d, 32'(got_bits), 32'(vecs[v].bits & msk));
      chk("vec_active_cycles", d, 32'(acc_act[d]), 32'(vecs[v].nbits * CPB));
      chk("vec_done_pulses",  d, 32'(acc_done[d]), 32'd1);
      chk("vec_overflow",     d, 32'(acc_ovf[d]), 32'd0);
      chk("vec_idle_after",   d, {29'd0, ser[d], act[d], empty[d]}, 32'b101);
    end

    // Burst of six writes into A: five accepted, one overflow, back-to-back frames.
    clear_acc();
    for (int i = 0; i < 6; i++) begin
      tb_data[0] = 9'(8'h31 + 8'(i * 17));
      tb_dv[0] = 1'b1;
      tick();
    end
    tb_dv[0] = 1'b0;
    for (int i = 0; i < 220; i++) tick();
    chk("burst_overflow_pulses", 0, 32'(acc_ovf[0]), 32'd1);
    chk("burst_done_pulses",     0, 32'(acc_done[0]), 32'd5);
    chk("burst_active_cycles",   0, 32'(acc_act[0]), 32'd200);
    chk("burst_active_runs",     0, 32'(acc_runs[0]), 32'd1);
    chk("burst_empty_after",     0, 32'(empty[0]), 32'd1);

    // Reset in the middle of a data bit with two bytes still queued.
    clear_acc();
    for (int i = 0; i < 3; i++) begin
      tb_data[0] = 9'(8'hC3 ^ 8'(i));
      tb_dv[0] = 1'b1;
      tick();
    end
    tb_dv[0] = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("midreset_active_before", 0, 32'(act[0]), 32'd1);
    chk("midreset_queued_before", 0, 32'(empty[0]), 32'd0);
    rst_n = 1'b0;
    tb_dv[0] = 1'b1;
    tick();
    chk("midreset_serial", 0, 32'(ser[0]), 32'd1);
    chk("midreset_active", 0, 32'(act[0]), 32'd0);
    chk("midreset_empty",  0, 32'(empty[0]), 32'd1);
    chk("midreset_done",   0, 32'(acc_done[0]), 32'd0);
    rst_n = 1'b1;
    tb_dv[0] = 1'b0;
    clear_acc();
    for (int i = 0; i < 150; i++) tick();
    chk("postreset_active", 0, 32'(acc_act[0]), 32'd0);
    chk("postreset_done",   0, 32'(acc_done[0]), 32'd0);
    chk("postreset_line_low", 0, 32'(acc_low[0]), 32'd0);

    // Randomized traffic on all instances, sparse then dense, rare resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NDUT; i++) begin
        tb_dv[i]   = ($urandom_range(0, (c < 1500) ? 29 : 2) == 0);
        tb_data[i] = 9'($urandom);
      end
      rst_n = ($urandom_range(0, 999) != 0);
      tick();
    end
    tb_dv = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    for (int i = 0; i < NDUT; i++) begin
      chk("drain_empty",  i, 32'(empty[i]), 32'd1);
      chk("drain_serial", i, 32'(ser[i]), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
